// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM encoding, requester ids and the round-robin pick helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGrantI = 2'b01,
        StGrantD = 2'b10,
        StDone   = 2'b11
    } arb_state_e;

    localparam logic PortI = 1'b0;
    localparam logic PortD = 1'b1;

    localparam int unsigned WaitCntWidth = 8;

    // Winner among the active requesters; a tie goes to the port that did not win last.
    function automatic logic pick_port(
        input logic ireq,
        input logic dreq,
        input logic last_grant
    );
        logic port;
        if (ireq && dreq) begin
            port = ~last_grant;
        end else if (dreq) begin
            port = PortD;
        end else begin
            port = PortI;
        end
        return port;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Memory wait-cycle watchdog: 8-bit counter that flags expiry once it has
// counted MaxWait unacknowledged cycles.
module wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MaxWait = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [WaitCntWidth-1:0] Limit = WaitCntWidth'(MaxWait);

    logic [WaitCntWidth-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between a 16-bit read-only
// instruction fetch path and an 8-bit read/write data path.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AddrSize  = 8,
    parameter int unsigned IRamWidth = 16,
    parameter int unsigned DRamWidth = 8,
    parameter int unsigned MaxWait   = 15,
    parameter logic [7:0]  DummyVal  = 8'b11111111
) (
    input  logic                 i_clk,
    input  logic                 i_reset,

    input  logic                 i_ireq,
    input  logic [AddrSize-1:0]  i_iaddr,
    output logic [IRamWidth-1:0] o_idata,
    output logic                 o_iready,

    input  logic                 i_dreq,
    input  logic                 i_dwrite,
    input  logic [AddrSize-1:0]  i_daddr,
    input  logic [DRamWidth-1:0] i_ddata_in,
    output logic [DRamWidth-1:0] o_ddata_out,
    output logic                 o_dready,

    output logic                 o_mem_req,
    output logic                 o_mem_write,
    output logic [AddrSize-1:0]  o_mem_addr,
    output logic [IRamWidth-1:0] o_mem_wdata,
    input  logic [IRamWidth-1:0] i_mem_rdata,
    input  logic                 i_mem_ack,

    output logic                 o_timeout,
    output logic                 o_owner
);

    localparam logic [IRamWidth-1:0] IDummy = IRamWidth'({DummyVal, DummyVal});
    localparam logic [DRamWidth-1:0] DDummy = DRamWidth'(DummyVal);

    arb_state_e           r_state;
    logic                 r_last_grant;
    logic                 r_owner;
    logic                 r_dwrite;
    logic [AddrSize-1:0]  r_addr;
    logic [IRamWidth-1:0] r_wdata;
    logic                 r_mem_req;
    logic                 r_mem_write;
    logic [IRamWidth-1:0] r_idata;
    logic [DRamWidth-1:0] r_ddata_out;
    logic                 r_iready;
    logic                 r_dready;
    logic                 r_timeout;

    logic w_grant;
    logic w_in_grant;
    logic w_expire;
    logic w_timer_clear;
    logic w_timer_enable;

    assign w_grant        = pick_port(i_ireq, i_dreq, r_last_grant);
    assign w_in_grant     = (r_state == StGrantI) || (r_state == StGrantD);
    assign w_timer_clear  = (r_state == StIdle);
    assign w_timer_enable = w_in_grant && !i_mem_ack && !w_expire;

    wait_timer #(
        .MaxWait (MaxWait)
    ) u_wait_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_enable),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_last_grant <= PortD;
            r_owner      <= PortI;
            r_dwrite     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_req    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_idata      <= '0;
            r_ddata_out  <= '0;
            r_iready     <= 1'b0;
            r_dready     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_iready  <= 1'b0;
            r_dready  <= 1'b0;
            r_timeout <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (i_ireq || i_dreq) begin
                        r_last_grant <= w_grant;
                        r_owner      <= w_grant;
                        r_mem_req    <= 1'b1;
                        if (w_grant == PortI) begin
                            r_state     <= StGrantI;
                            r_addr      <= i_iaddr;
                            r_mem_write <= 1'b0;
                        end else begin
                            r_state     <= StGrantD;
                            r_addr      <= i_daddr;
                            r_dwrite    <= i_dwrite;
                            r_mem_write <= i_dwrite;
                            r_wdata     <= IRamWidth'(i_ddata_in);
                        end
                    end
                end

                StGrantI, StGrantD: begin
                    // Ack takes precedence over the watchdog when both land together.
                    if (i_mem_ack || w_expire) begin
                        r_state     <= StDone;
                        r_mem_req   <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_timeout   <= !i_mem_ack;
                        if (r_state == StGrantI) begin
                            r_iready <= 1'b1;
                            r_idata  <= i_mem_ack ? i_mem_rdata : IDummy;
                        end else begin
                            r_dready <= 1'b1;
                            if (!r_dwrite) begin
                                r_ddata_out <= i_mem_ack ? i_mem_rdata[DRamWidth-1:0] : DDummy;
                            end
                        end
                    end
                end

                StDone: begin
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_idata     = r_idata;
    assign o_iready    = r_iready;
    assign o_ddata_out = r_ddata_out;
    assign o_dready    = r_dready;
    assign o_mem_req   = r_mem_req;
    assign o_mem_write = r_mem_write;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_timeout   = r_timeout;
    assign o_owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        ireq;
    logic [7:0]  iaddr;
    logic [15:0] idata;
    logic        iready;
    logic        dreq;
    logic        dwrite;
    logic [7:0]  daddr;
    logic [7:0]  ddata_in;
    logic [7:0]  ddata_out;
    logic        dready;
    logic        mem_req;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        timeout;
    logic        owner;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .AddrSize  (8),
        .IRamWidth (16),
        .DRamWidth (8),
        .MaxWait   (15),
        .DummyVal  (8'hFF)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_ireq      (ireq),
        .i_iaddr     (iaddr),
        .o_idata     (idata),
        .o_iready    (iready),
        .i_dreq      (dreq),
        .i_dwrite    (dwrite),
        .i_daddr     (daddr),
        .i_ddata_in  (ddata_in),
        .o_ddata_out (ddata_out),
        .o_dready    (dready),
        .o_mem_req   (mem_req),
        .o_mem_write (mem_write),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack),
        .o_timeout   (timeout),
        .o_owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic        tie_owner [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] tie_rdata [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] tie_idata [4] = '{16'h1111, 16'h1111, 16'h3333, 16'h3333};
    logic [7:0]  tie_ddata [4] = '{8'h00, 8'h22, 8'h22, 8'h44};

    initial begin
        reset = 1'b1; ireq = 0; iaddr = 0; dreq = 0; dwrite = 0; daddr = 0;
        ddata_in = 0; mem_rdata = 0; mem_ack = 0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_idata", idata, 0);
        check_eq("rst_ddata", ddata_out, 0);
        check_eq("rst_ready", {iready, dready, timeout}, 0);
        check_eq("rst_owner", owner, 0);

        // I-port only, ack in cycle 1 (ack high while idle must be ignored)
        ireq = 1; iaddr = 8'h10; mem_ack = 1; mem_rdata = 16'hA55A;
        tick();
        check_eq("i_mem_req", mem_req, 1);
        check_eq("i_mem_addr", mem_addr, 8'h10);
        check_eq("i_mem_write", mem_write, 0);
        check_eq("i_owner", owner, 0);
        check_eq("i_no_ready_c1", iready, 0);
        tick();
        check_eq("i_iready", iready, 1);
        check_eq("i_idata", idata, 16'hA55A);
        check_eq("i_done_mem_req", mem_req, 0);
        check_eq("i_done_mem_write", mem_write, 0);
        check_eq("i_timeout", timeout, 0);
        ireq = 0; mem_ack = 0;
        tick();
        check_eq("i_ready_pulse", iready, 0);

        // D write with 3 wait cycles; input changes after grant must not matter
        dreq = 1; dwrite = 1; daddr = 8'h20; ddata_in = 8'h3C;
        tick();
        check_eq("dw_c1_req", mem_req, 1);
        check_eq("dw_c1_write", mem_write, 1);
        check_eq("dw_c1_wdata", mem_wdata, 16'h003C);
        check_eq("dw_c1_addr", mem_addr, 8'h20);
        check_eq("dw_owner", owner, 1);
        daddr = 8'h55; ddata_in = 8'h00; dwrite = 0;
        tick();
        check_eq("dw_c2_wdata", mem_wdata, 16'h003C);
        check_eq("dw_c2_addr", mem_addr, 8'h20);
        tick();
        check_eq("dw_c3_write", mem_write, 1);
        tick();
        check_eq("dw_c4_req", mem_req, 1);
        check_eq("dw_c4_wdata", mem_wdata, 16'h003C);
        check_eq("dw_c4_no_ready", dready, 0);
        mem_ack = 1;
        tick();
        check_eq("dw_c5_dready", dready, 1);
        check_eq("dw_c5_ddata", ddata_out, 8'h00);
        check_eq("dw_c5_mem_req", mem_req, 0);
        check_eq("dw_c5_timeout", timeout, 0);
        dreq = 0; mem_ack = 0; dwrite = 0;
        tick();

        // Tie: both held, zero-wait ack; last grant was D so order is I, D, I, D
        ireq = 1; dreq = 1; mem_ack = 1;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = tie_rdata[k];
            tick();
            check_eq($sformatf("tie%0d_owner", k), owner, tie_owner[k]);
            check_eq($sformatf("tie%0d_req", k), mem_req, 1);
            tick();
            check_eq($sformatf("tie%0d_ready", k), {iready, dready},
                     tie_owner[k] ? 2'b01 : 2'b10);
            check_eq($sformatf("tie%0d_idata", k), idata, tie_idata[k]);
            check_eq($sformatf("tie%0d_ddata", k), ddata_out, tie_ddata[k]);
            tick();
            check_eq($sformatf("tie%0d_idle_req", k), mem_req, 0);
        end
        ireq = 0; dreq = 0; mem_ack = 0;

        // Timeout on D read: ready + timeout at cycle 17
        dreq = 1; dwrite = 0; daddr = 8'h30; mem_rdata = 16'h5A5A;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check_eq($sformatf("to_c%0d_req", c), mem_req, 1);
            check_eq($sformatf("to_c%0d_ready", c), dready, 0);
        end
        tick();
        check_eq("to_dready", dready, 1);
        check_eq("to_timeout", timeout, 1);
        check_eq("to_ddata", ddata_out, 8'hFF);
        check_eq("to_mem_req", mem_req, 0);
        dreq = 0;
        tick();
        check_eq("to_pulse", {dready, timeout}, 0);

        // Reset during GRANT_D with ack pending
        dreq = 1; dwrite = 0; daddr = 8'h40;
        tick();
        check_eq("rs_grant_req", mem_req, 1);
        reset = 1; mem_ack = 1;
        tick();
        reset = 0; dreq = 0; mem_ack = 0;
        check_eq("rs_mem_req", mem_req, 0);
        check_eq("rs_dready", dready, 0);
        check_eq("rs_idata_cleared", idata, 0);
        tick();
        check_eq("rs_no_retry_req", mem_req, 0);
        check_eq("rs_no_retry_ready", dready, 0);
        ireq = 1; dreq = 1; iaddr = 8'h77; mem_ack = 1; mem_rdata = 16'hBEEF;
        tick();
        check_eq("rs_i_prio_owner", owner, 0);
        check_eq("rs_i_addr", mem_addr, 8'h77);
        tick();
        check_eq("rs_iready", iready, 1);
        check_eq("rs_idata", idata, 16'hBEEF);
        ireq = 0; dreq = 0; mem_ack = 0;
        tick();

        // Ack arrives exactly at the watchdog limit: ack wins
        dreq = 1; dwrite = 0; daddr = 8'h50; mem_rdata = 16'h0042;
        for (int c = 1; c <= 16; c++) begin
            tick();
        end
        check_eq("co_c16_req", mem_req, 1);
        mem_ack = 1;
        tick();
        check_eq("co_dready", dready, 1);
        check_eq("co_timeout", timeout, 0);
        check_eq("co_ddata", ddata_out, 8'h42);
        dreq = 0; mem_ack = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
